config_chain_loader: RTL

Serial configuration-bitstream loader placed directly upstream of a CGRA processing element's configuration scan chain (the mux-select, function-select and constant cells of a VLIW ADRES PE). It accepts configuration words from a host/DMA over a valid/ready handshake and serialises them LSB-first onto the chain head. It also drives a shift-enable that qualifies every chain shift. An optional verify pass circulates the chain back through itself and checks its contents by CRC.

---
 rtl/config_chain_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// config_chain_loader: serialises host configuration words LSB-first onto a PE
// configuration scan chain, with an optional CRC verify pass (macro
// CONFIG_CHAIN_VERIFY_EN) that circulates the chain through itself.
// Ports: Config_Clock/Config_Reset (sync, active-low), start, word_in/word_valid/
// word_ready host handshake, ConfigOut/shift_en to chain head, ConfigIn from
// chain tail, busy/done/error status.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 48
) (
  input  logic                  Config_Clock,
  input  logic                  Config_Reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ConfigOut,
  output logic                  shift_en,
  input  logic                  ConfigIn,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BCW = $clog2(WORD_WIDTH + 1);

`ifdef CONFIG_CHAIN_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WAIT_WORD, SHIFT, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]           total_cnt_q, total_cnt_d;
  logic                  shift_en_q, shift_en_d;
  logic                  config_out_q, config_out_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

`ifdef CONFIG_CHAIN_VERIFY_EN
  logic [15:0] crc_tx_q, crc_tx_d;
  logic [15:0] crc_rx_q, crc_rx_d;

  // CRC-16-CCITT, one bit per call, MSB-first feedback.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // Outputs are scheduled one cycle ahead: shift_en/ConfigOut are computed for
  // the state being entered, so shift_en is high exactly in SHIFT/VERIFY cycles.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    total_cnt_d  = total_cnt_q;
    shift_en_d   = 1'b0;
    config_out_d = 1'b0;
    done_d       = 1'b0;
    error_d      = error_q;
`ifdef CONFIG_CHAIN_VERIFY_EN
    crc_tx_d     = crc_tx_q;
    crc_rx_d     = crc_rx_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT_WORD;
          error_d     = 1'b0;
          bit_cnt_d   = '0;
          total_cnt_d = '0;
`ifdef CONFIG_CHAIN_VERIFY_EN
          crc_tx_d    = 16'hFFFF;
          crc_rx_d    = 16'hFFFF;
`endif
        end
      end
      WAIT_WORD: begin
        if (word_valid) begin
          // Bit 0 goes out next cycle; the register keeps the remaining bits.
          state_d      = SHIFT;
          shreg_d      = word_in >> 1;
          config_out_d = word_in[0];
          shift_en_d   = 1'b1;
          bit_cnt_d    = BCW'(1);
          total_cnt_d  = total_cnt_q + 16'd1;
`ifdef CONFIG_CHAIN_VERIFY_EN
          crc_tx_d     = crc_step(crc_tx_q, word_in[0]);
`endif
        end
      end
      SHIFT: begin
        // The current cycle carries the last bit of this word (full word or
        // the truncated final word).
        if (bit_cnt_q == BCW'(WORD_WIDTH) || total_cnt_q == 16'(CHAIN_LENGTH)) begin
          if (total_cnt_q == 16'(CHAIN_LENGTH)) begin
`ifdef CONFIG_CHAIN_VERIFY_EN
            // total_cnt is reused to count the verify cycles.
            state_d     = VERIFY;
            shift_en_d  = 1'b1;
            total_cnt_d = 16'd1;
`else
            state_d     = DONE;
            done_d      = 1'b1;
`endif
          end else begin
            state_d = WAIT_WORD;
          end
        end else begin
          config_out_d = shreg_q[0];
          shreg_d      = shreg_q >> 1;
          shift_en_d   = 1'b1;
          bit_cnt_d    = bit_cnt_q + BCW'(1);
          total_cnt_d  = total_cnt_q + 16'd1;
`ifdef CONFIG_CHAIN_VERIFY_EN
          crc_tx_d     = crc_step(crc_tx_q, shreg_q[0]);
`endif
        end
      end
`ifdef CONFIG_CHAIN_VERIFY_EN
      VERIFY: begin
        crc_rx_d = crc_step(crc_rx_q, ConfigIn);
        if (total_cnt_q == 16'(CHAIN_LENGTH)) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (crc_rx_d != crc_tx_q) error_d = 1'b1;
        end else begin
          shift_en_d  = 1'b1;
          total_cnt_d = total_cnt_q + 16'd1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Config_Clock) begin
    if (!Config_Reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      total_cnt_q  <= '0;
      shift_en_q   <= 1'b0;
      config_out_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef CONFIG_CHAIN_VERIFY_EN
      crc_tx_q     <= 16'hFFFF;
      crc_rx_q     <= 16'hFFFF;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      total_cnt_q  <= total_cnt_d;
      shift_en_q   <= shift_en_d;
      config_out_q <= config_out_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef CONFIG_CHAIN_VERIFY_EN
      crc_tx_q     <= crc_tx_d;
      crc_rx_q     <= crc_rx_d;
`endif
    end
  end

  assign word_ready = (state_q == WAIT_WORD);
  assign busy       = (state_q != IDLE);
  assign shift_en   = shift_en_q;
  assign done       = done_q;
  assign error      = error_q;

`ifdef CONFIG_CHAIN_VERIFY_EN
  // Loopback during verify: the tail feeds straight back into the head.
  assign ConfigOut = (state_q == VERIFY) ? ConfigIn : config_out_q;
`else
  logic unused_config_in;
  assign unused_config_in = ConfigIn;
  assign ConfigOut = config_out_q;
`endif

endmodule
